// File: rtl/riscv_pkg.sv
// Shared core definitions: opcodes, NOP encoding and
// the memory-port arbiter state encoding.
package riscv_pkg;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [31:0] NOP_ENC  = 32'h00000013;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DATA  = 2'd1,
        ARB_INSTR = 2'd2
    } arbState_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for the memory port; flags the cycle in which
// the TIMEOUT_CYCLES-th consecutive wait cycle occurs.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // Reaching the limit is this edge, so abort as part of it.
    assign expired = en & (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store,
// stalling the pipeline until every request of the cycle is served.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = NOP_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_re,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] if_rdata,
    output logic [31:0] dm_rdata,
    output logic        stall,
    output logic        bus_err
);

    arbState_t   stateQ, stateD;
    logic        validD, weD;
    logic [31:0] addrD, wdataD;
    logic        dmSrv, ifSrv;
    logic        dmPend, ifPend;
    logic        busy, done, expired;

    assign dmPend = (dm_re | dm_we) & ~dmSrv;
    assign ifPend = if_req & ~ifSrv;
    assign stall  = dmPend | ifPend;
    assign busy   = stateQ != ARB_IDLE;
    assign done   = busy & (mem_ready | expired);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimeout (
        .clk    (clk),
        .rst    (rst),
        .en     (busy & ~mem_ready),
        .clr    (~busy | done),
        .expired(expired)
    );

    always_comb begin
        stateD = stateQ;
        validD = mem_valid;
        weD    = mem_we;
        addrD  = mem_addr;
        wdataD = mem_wdata;
        unique case (stateQ)
            ARB_IDLE: begin
                // Data first: it belongs to the older instruction.
                if (dmPend) begin
                    stateD = ARB_DATA;
                    validD = 1'b1;
                    weD    = dm_we;
                    addrD  = dm_addr;
                    wdataD = dm_wdata;
                end else if (ifPend) begin
                    stateD = ARB_INSTR;
                    validD = 1'b1;
                    weD    = 1'b0;
                    addrD  = if_addr;
                end else begin
                    validD = 1'b0;
                end
            end
            ARB_DATA, ARB_INSTR: begin
                if (done) begin
                    stateD = ARB_IDLE;
                    validD = 1'b0;
                end
            end
            default: begin
                stateD = ARB_IDLE;
                validD = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= ARB_IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
            dmSrv     <= 1'b0;
            ifSrv     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            mem_valid <= validD;
            mem_we    <= weD;
            mem_addr  <= addrD;
            mem_wdata <= wdataD;
            if (done && stateQ == ARB_DATA && !mem_we)
                dm_rdata <= expired ? '0 : mem_rdata;
            if (done && stateQ == ARB_INSTR)
                if_rdata <= expired ? NOP_INSTR : mem_rdata;
            if (expired)
                bus_err <= 1'b1;
            // An advancing pipeline starts a fresh set of requests.
            if (!stall) begin
                dmSrv <= 1'b0;
                ifSrv <= 1'b0;
            end else if (done) begin
                if (stateQ == ARB_DATA) dmSrv <= 1'b1;
                else                    ifSrv <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-cycle timeout.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_re, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        mem_valid, mem_we, stall, bus_err;
    logic [31:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

    int nAsserts = 0;
    int nFails   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(4),
        .NOP_INSTR     (32'h00000013)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .if_rdata (if_rdata),
        .dm_rdata (dm_rdata),
        .stall    (stall),
        .bus_err  (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        nAsserts++;
        assert (obs === want) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; dm_re = 0; dm_we = 0; mem_ready = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        tick(); tick(); settle();
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_ifrd", if_rdata, 32'd0);
        chk("rst_dmrd", dm_rdata, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;

        // Zero-wait fetch
        tick();
        if_req = 1; if_addr = 32'h100;
        mem_ready = 1; mem_rdata = 32'h00500093;
        settle();
        chk("f0_stall", {31'd0, stall}, 32'd1);
        chk("f0_valid", {31'd0, mem_valid}, 32'd0);
        tick(); settle();
        chk("f1_valid", {31'd0, mem_valid}, 32'd1);
        chk("f1_addr", mem_addr, 32'h100);
        chk("f1_we", {31'd0, mem_we}, 32'd0);
        chk("f1_stall", {31'd0, stall}, 32'd1);
        tick(); settle();
        chk("f2_ifrd", if_rdata, 32'h00500093);
        chk("f2_stall", {31'd0, stall}, 32'd0);
        chk("f2_valid", {31'd0, mem_valid}, 32'd0);
        if_req = 0; mem_ready = 0;

        // Load plus fetch, two wait states each
        tick();
        dm_re = 1; dm_addr = 32'h200;
        if_req = 1; if_addr = 32'h104;
        mem_rdata = 32'hAAAA5555;
        settle();
        chk("lf0_stall", {31'd0, stall}, 32'd1);
        tick(); settle();
        chk("lf1_valid", {31'd0, mem_valid}, 32'd1);
        chk("lf1_addr", mem_addr, 32'h200);
        chk("lf1_we", {31'd0, mem_we}, 32'd0);
        tick(); settle();
        chk("lf2_addr", mem_addr, 32'h200);
        tick();
        mem_ready = 1; mem_rdata = 32'h11223344;
        settle();
        chk("lf3_valid", {31'd0, mem_valid}, 32'd1);
        tick();
        mem_ready = 0;
        settle();
        chk("lf4_valid", {31'd0, mem_valid}, 32'd0);
        chk("lf4_dmrd", dm_rdata, 32'h11223344);
        chk("lf4_stall", {31'd0, stall}, 32'd1);
        tick(); settle();
        chk("lf5_valid", {31'd0, mem_valid}, 32'd1);
        chk("lf5_addr", mem_addr, 32'h104);
        chk("lf5_we", {31'd0, mem_we}, 32'd0);
        tick(); settle();
        chk("lf6_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_ready = 1; mem_rdata = 32'h00A00113;
        settle();
        chk("lf7_addr", mem_addr, 32'h104);
        tick(); settle();
        chk("lf8_stall", {31'd0, stall}, 32'd0);
        chk("lf8_ifrd", if_rdata, 32'h00A00113);
        chk("lf8_dmrd", dm_rdata, 32'h11223344);
        chk("lf8_valid", {31'd0, mem_valid}, 32'd0);
        dm_re = 0; if_req = 0; mem_ready = 0;

        // Store with three wait states; inputs move while in flight
        tick();
        dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'hDEADBEEF;
        mem_rdata = 32'hFFFFFFFF;
        settle();
        chk("st0_stall", {31'd0, stall}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            dm_addr = 32'h0BAD0000 + i; dm_wdata = 32'h0;
            settle();
            chk("st_valid", {31'd0, mem_valid}, 32'd1);
            chk("st_we", {31'd0, mem_we}, 32'd1);
            chk("st_addr", mem_addr, 32'h300);
            chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        end
        tick();
        mem_ready = 1;
        settle();
        chk("st4_addr", mem_addr, 32'h300);
        tick(); settle();
        chk("st5_stall", {31'd0, stall}, 32'd0);
        chk("st5_dmrd", dm_rdata, 32'h11223344);
        chk("st5_err", {31'd0, bus_err}, 32'd0);
        dm_we = 0; mem_ready = 0;

        // Load and store together is a store
        tick();
        dm_re = 1; dm_we = 1;
        dm_addr = 32'h304; dm_wdata = 32'h12345678;
        mem_ready = 1;
        settle();
        tick(); settle();
        chk("rw1_we", {31'd0, mem_we}, 32'd1);
        chk("rw1_addr", mem_addr, 32'h304);
        chk("rw1_wdata", mem_wdata, 32'h12345678);
        tick(); settle();
        chk("rw2_stall", {31'd0, stall}, 32'd0);
        chk("rw2_dmrd", dm_rdata, 32'h11223344);
        dm_re = 0; dm_we = 0; mem_ready = 0;

        // Fetch timeout after four wait cycles
        tick();
        if_req = 1; if_addr = 32'h108;
        mem_rdata = 32'h55555555;
        settle();
        for (int i = 1; i <= 4; i++) begin
            tick(); settle();
            chk("to_valid", {31'd0, mem_valid}, 32'd1);
            chk("to_err", {31'd0, bus_err}, 32'd0);
            chk("to_stall", {31'd0, stall}, 32'd1);
        end
        tick(); settle();
        chk("to5_valid", {31'd0, mem_valid}, 32'd0);
        chk("to5_ifrd", if_rdata, 32'h00000013);
        chk("to5_err", {31'd0, bus_err}, 32'd1);
        chk("to5_stall", {31'd0, stall}, 32'd0);
        if_req = 0;
        tick(); tick(); settle();
        chk("to7_err", {31'd0, bus_err}, 32'd1);

        // Reset in the middle of a data transfer
        tick();
        dm_re = 1; dm_addr = 32'h400;
        settle();
        tick(); settle();
        chk("rm1_valid", {31'd0, mem_valid}, 32'd1);
        chk("rm1_addr", mem_addr, 32'h400);
        rst = 1'b0;
        tick(); settle();
        chk("rm2_valid", {31'd0, mem_valid}, 32'd0);
        chk("rm2_err", {31'd0, bus_err}, 32'd0);
        chk("rm2_ifrd", if_rdata, 32'd0);
        chk("rm2_dmrd", dm_rdata, 32'd0);
        chk("rm2_stall", {31'd0, stall}, 32'd1);
        dm_re = 0;
        settle();
        chk("rm2_nostall", {31'd0, stall}, 32'd0);
        dm_re = 1;
        rst = 1'b1;
        tick();
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        settle();
        chk("rm3_valid", {31'd0, mem_valid}, 32'd1);
        chk("rm3_addr", mem_addr, 32'h400);
        tick(); settle();
        chk("rm4_dmrd", dm_rdata, 32'hCAFEF00D);
        chk("rm4_stall", {31'd0, stall}, 32'd0);
        dm_re = 0; mem_ready = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single unified memory port between instruction fetch (IF) and data access (MEM stage loads/stores decoded from the load/store opcodes). It sequences one transfer at a time over a valid/ready memory handshake and freezes the pipeline with a global stall until every pending request of the current cycle has been served. It sits between the pipeline stage registers and the external memory model or bus.

Parameters:
TIMEOUT_CYCLES, 255, wait cycles with mem_valid=1 and mem_ready=0 before a transfer is aborted; legal range 1..65535.
NOP_INSTR, 32'h00000013, instruction word returned on an aborted fetch (addi x0,x0,0).

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
if_req  in  1  fetch request for the current cycle.
if_addr  in  32  fetch address (PCF).
dm_re  in  1  load request (MEM stage, ResultSrc=1).
dm_we  in  1  store request (MEM stage, MemWrite=1).
dm_addr  in  32  data address (ALU result).
dm_wdata  in  32  store data.
mem_ready  in  1  memory accepts or completes the presented transfer.
mem_rdata  in  32  read data, valid when mem_valid & mem_ready.
mem_valid  out  1  transfer presented.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  32  transfer address.
mem_wdata  out  32  write data.
if_rdata  out  32  last fetched instruction word, held.
dm_rdata  out  32  last load data, held.
stall  out  1  freezes all pipeline registers and the PC.
bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE. mem_valid, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, bus_err, the served flags and the timeout counter all become 0. A reset asserted mid-transfer abandons the transfer, and mem_valid is 0 after that edge.
- dm_req = dm_re | dm_we. If dm_re and dm_we are both 1, the request is a store.
- Served flags dm_srv and if_srv:
  - Each is set at the edge where its transfer completes.
  - Both clear at any edge where stall=0, i.e. when the pipeline advances.
- stall is combinational: stall = (dm_req & ~dm_srv) | (if_req & ~if_srv). It has no dependence on mem_ready in the same cycle.
- FSM states: IDLE, DATA, INSTR.
  - IDLE: if dm_req & ~dm_srv, go to DATA and load mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata, mem_valid=1.
  - IDLE: else if if_req & ~if_srv, go to INSTR and load mem_addr=if_addr, mem_we=0, mem_valid=1.
  - IDLE: otherwise stay, with mem_valid=0.
  - Data has priority over fetch because it belongs to the older instruction.
  - DATA/INSTR: mem_* outputs are held stable while mem_ready=0.
  - DATA/INSTR, on mem_ready=1: complete, go to IDLE, mem_valid=0 next cycle, set the matching served flag, and capture mem_rdata into dm_rdata (loads only) or if_rdata.
  - A store leaves dm_rdata unchanged.
- Latency: request at cycle N, mem_valid at N+1. With zero-wait memory, completion is at N+1 and data is held from N+2. A following transfer is issued no earlier than N+3 (one IDLE bubble).
- Timeout counter:
  - Counts cycles in DATA/INSTR with mem_ready=0; clears on entering IDLE.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, the transfer is aborted and treated as complete at that edge.
  - On abort, dm_rdata=0 for a load, or if_rdata=NOP_INSTR for a fetch; bus_err is set and stays 1 until reset.
- Requests that drop while unserved (e.g. a flush) are not issued. A transfer already in flight still completes.
- mem_ready outside DATA/INSTR is ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OP_LOAD=7'b0000011 and OP_STORE=7'b0100011;
  - NOP encoding 32'h00000013;
  - arbiter state encoding ARB_IDLE=2'd0, ARB_DATA=2'd1, ARB_INSTR=2'd2.
- One natural sub-module: mem_timeout_counter. Interface: clk, rst, en, clr, expired. It is parameterised by TIMEOUT_CYCLES and its width is clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Zero-wait fetch only: if_req=1, if_addr=0x100, mem_ready=1, mem_rdata=0x00500093. Required: mem_valid at cycle 1 with addr 0x100; if_rdata=0x00500093 at cycle 2; stall=1 in cycles 0-1 and 0 in cycle 2.
- Load plus fetch in the same cycle: dm_re=1, dm_addr=0x200, if_addr=0x104, memory 2 wait states. Required: DATA transfer to 0x200 first, then INSTR to 0x104, one IDLE cycle between; stall stays 1 until the fetch completes; dm_rdata and if_rdata are both correct when stall falls.
- Store: dm_we=1, dm_addr=0x300, dm_wdata=0xDEADBEEF. Required: mem_we=1 with stable addr and data across 3 wait cycles; dm_rdata unchanged.
- Timeout, TIMEOUT_CYCLES=4, mem_ready held 0 on a fetch. Required: abort after 4 wait cycles; if_rdata=0x00000013; bus_err=1 and stays 1 until rst=0.
- Reset mid-transfer: rst=0 while in DATA with mem_ready=0. Required: next cycle mem_valid=0, stall follows the requests, all served flags cleared.
- dm_re=dm_we=1: required to be issued as a store (mem_we=1).
